// File: rtl/eth_rx_frame_buf.sv
// GMII rx frame buffer: strips preamble/SFD and queues each frame into a slot FIFO for random-access reads.
// Latency: frm_valid rises 1 clock after rx_dv falls on a committed frame; rd_data is registered, 1 clock.
// Backpressure: none toward the PHY; when every slot is occupied at SFD time the whole frame is dropped and counted.
//
// Ports:
//   i_clock, i_reset_n        rx byte clock, synchronous active-low reset
//   i_rx_dv, i_rx_data        GMII receive valid / byte
//   o_frm_valid, o_frm_len    oldest stored frame present / its byte count (SFD excluded, FCS included)
//   i_rd_addr, o_rd_data      byte offset into the oldest frame / registered byte
//   i_frm_release             pulse: free the oldest frame
//   o_drop_cnt, o_fcs_err_cnt saturating drop counters (full/overlong/runt, bad FCS)
// Optional feature: define ETH_RX_FCS_CHECK_EN to drop frames whose CRC-32 residue is wrong.

module eth_rx_frame_buf #(
    parameter int ADDR_W  = 10,
    parameter int SLOT_W  = 1,
    parameter int CNT_W   = 16,
    parameter int MIN_LEN = 14
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_data,
    output logic              o_frm_valid,
    output logic [ADDR_W:0]   o_frm_len,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    input  logic              i_frm_release,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [CNT_W-1:0]  o_fcs_err_cnt
);

    localparam int NSLOT = 2**SLOT_W;
    localparam int DEPTH = 2**(ADDR_W + SLOT_W);
    localparam logic [ADDR_W:0] MIN_LEN_V = (ADDR_W+1)'(MIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W:0]   r_len [NSLOT];
    logic [SLOT_W-1:0] r_head;
    logic [SLOT_W-1:0] r_tail;
    logic [SLOT_W:0]   r_count;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [7:0]        r_rd_data;

    logic w_full;
    logic w_release;
    logic w_wr_en;
    logic w_ptr_clr;
    logic w_commit;
    logic w_drop_inc;

    // count can only reach NSLOT, so its MSB alone means "every slot used"
    assign w_full      = r_count[SLOT_W];
    assign o_frm_valid = (r_count != '0);
    assign w_release   = i_frm_release & o_frm_valid;
    assign o_frm_len   = o_frm_valid ? r_len[r_head] : '0;
    assign o_rd_data   = r_rd_data;
    assign o_drop_cnt  = r_drop_cnt;

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0]      r_crc;
    logic [CNT_W-1:0] r_fcs_cnt;
    logic             w_fcs_bad;
    logic             w_fcs_inc;

    // reflected CRC-32, one byte per call, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // running the register over data plus the received FCS leaves this constant when intact
    assign w_fcs_bad     = (r_crc != 32'hDEBB20E3);
    assign o_fcs_err_cnt = r_fcs_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_crc     <= '1;
            r_fcs_cnt <= '0;
        end else begin
            if (w_ptr_clr) begin
                r_crc <= '1;
            end else if (w_wr_en) begin
                r_crc <= crc32_byte(r_crc, i_rx_data);
            end
            if (w_fcs_inc && (r_fcs_cnt != '1)) begin
                r_fcs_cnt <= r_fcs_cnt + 1'b1;
            end
        end
    end
`else
    assign o_fcs_err_cnt = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_ptr_clr   = 1'b0;
        w_commit    = 1'b0;
        w_drop_inc  = 1'b0;
`ifdef ETH_RX_FCS_CHECK_EN
        w_fcs_inc   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_rx_dv) begin
                    w_state_nxt = (i_rx_data == 8'h55) ? S_PRE : S_DROP;
                end
            end
            S_PRE: begin
                if (!i_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end else if (i_rx_data == 8'hD5) begin
                    // full is judged here so a stored frame is never overwritten
                    w_state_nxt = w_full ? S_DROP : S_DATA;
                    w_ptr_clr   = 1'b1;
                end else if (i_rx_data != 8'h55) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (i_rx_dv) begin
                    // ptr MSB set means the slot already holds 2**ADDR_W bytes
                    if (r_wr_ptr[ADDR_W]) begin
                        w_state_nxt = S_DROP;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    if (r_wr_ptr < MIN_LEN_V) begin
                        w_drop_inc = 1'b1;
                    end else begin
`ifdef ETH_RX_FCS_CHECK_EN
                        if (w_fcs_bad) begin
                            w_fcs_inc = 1'b1;
                        end else begin
                            w_commit = 1'b1;
                        end
`else
                        w_commit = 1'b1;
`endif
                    end
                end
            end
            S_DROP: begin
                if (!i_rx_dv) begin
                    w_state_nxt = S_IDLE;
                    w_drop_inc  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_drop_cnt <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ptr_clr) begin
                r_wr_ptr <= '0;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_release) begin
                r_head <= r_head + 1'b1;
            end
            // commit and release together leave the occupancy unchanged
            case ({w_commit, w_release})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop_inc && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            r_rd_data <= r_mem[{r_head, i_rd_addr}];
        end
    end

    // storage has no reset: contents only matter once a length is committed
    always_ff @(posedge i_clock) begin
        if (w_wr_en) begin
            r_mem[{r_tail, r_wr_ptr[ADDR_W-1:0]}] <= i_rx_data;
        end
        if (w_commit) begin
            r_len[r_tail] <= r_wr_ptr;
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
`timescale 1ns/1ps
module tb_eth_rx_frame_buf;

    localparam int ADDR_W  = 10;
    localparam int SLOT_W  = 1;
    localparam int CNT_W   = 16;
    localparam int MIN_LEN = 14;
    localparam int NSLOT   = 2;
    localparam int MAXB    = 1 << ADDR_W;
`ifdef ETH_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rx_dv;
    logic [7:0]        rx_data;
    logic              frm_valid;
    logic [ADDR_W:0]   frm_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frm_release;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  fcs_err_cnt;

    always #5 clk = ~clk;

    eth_rx_frame_buf #(
        .ADDR_W (ADDR_W),
        .SLOT_W (SLOT_W),
        .CNT_W  (CNT_W),
        .MIN_LEN(MIN_LEN)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_rx_dv      (rx_dv),
        .i_rx_data    (rx_data),
        .o_frm_valid  (frm_valid),
        .o_frm_len    (frm_len),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .i_frm_release(frm_release),
        .o_drop_cnt   (drop_cnt),
        .o_fcs_err_cnt(fcs_err_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference: stored frames as a length queue plus concatenated bytes, head first
    int         exp_lens[$];
    logic [7:0] exp_bytes[$];
    int         exp_drop = 0;
    int         exp_fcs  = 0;
    logic [7:0] fb [0:MAXB+8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input int n);
        logic [31:0] f;
        if (n < 4) return 1'b0;
        f = fcs_of(n - 4);
        return {fb[n-1], fb[n-2], fb[n-3], fb[n-4]} == f;
    endfunction

    task automatic build(input int len, input bit good);
        logic [31:0] f;
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
        if (good && len >= 4) begin
            f = fcs_of(len - 4);
            fb[len-4] = f[7:0];
            fb[len-3] = f[15:8];
            fb[len-2] = f[23:16];
            fb[len-1] = f[31:24];
        end
    endtask

    task automatic model_pop();
        int n;
        logic [7:0] d;
        if (exp_lens.size() > 0) begin
            n = exp_lens.pop_front();
            for (int i = 0; i < n; i++) d = exp_bytes.pop_front();
        end
    endtask

    // sends preamble, SFD and fb[0:len-1]; optionally pulses release on the rx_dv falling cycle
    task automatic send(input int len, input int npre, input bit rel_end);
        bit full_at_sfd;
        full_at_sfd = (exp_lens.size() >= NSLOT);
        for (int i = 0; i < npre; i++) begin
            rx_dv = 1'b1; rx_data = 8'h55; tick();
        end
        rx_data = 8'hD5; tick();
        for (int i = 0; i < len; i++) begin
            rx_data = fb[i]; tick();
        end
        rx_dv = 1'b0; rx_data = 8'h00; frm_release = rel_end;
        tick();
        frm_release = 1'b0;
        if (rel_end) model_pop();
        if (full_at_sfd || len > MAXB || len < MIN_LEN) exp_drop++;
        else if (FCS_EN && !fcs_ok(len)) exp_fcs++;
        else begin
            exp_lens.push_back(len);
            for (int i = 0; i < len; i++) exp_bytes.push_back(fb[i]);
        end
    endtask

    task automatic release_one();
        frm_release = 1'b1; tick(); frm_release = 1'b0;
        model_pop();
    endtask

    task automatic check_state(input string tag, input int nreads);
        int a;
        chk({tag, ".valid"}, 32'(frm_valid), 32'(exp_lens.size() != 0));
        chk({tag, ".len"}, 32'(frm_len), (exp_lens.size() != 0) ? exp_lens[0] : 0);
        chk({tag, ".drop"}, 32'(drop_cnt), exp_drop);
        chk({tag, ".fcs"}, 32'(fcs_err_cnt), exp_fcs);
        if (exp_lens.size() != 0) begin
            for (int k = 0; k < nreads; k++) begin
                a = $urandom_range(0, exp_lens[0] - 1);
                rd_addr = a[ADDR_W-1:0];
                tick();
                chk({tag, ".rd"}, 32'(rd_data), 32'(exp_bytes[a]));
            end
        end
    endtask

    initial begin
        int len;
        int a;
        reset_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; rd_addr = '0; frm_release = 1'b0;
        tick(); tick();
        chk("reset.valid", 32'(frm_valid), 0);
        chk("reset.len", 32'(frm_len), 0);
        chk("reset.rd", 32'(rd_data), 0);
        chk("reset.drop", 32'(drop_cnt), 0);
        chk("reset.fcs", 32'(fcs_err_cnt), 0);
        reset_n = 1'b1;
        tick();

        // basic 60-byte frame, byte 5 readable one clock after addressing it
        build(60, 1'b1);
        send(60, 7, 1'b0);
        check_state("t1", 3);
        rd_addr = 10'd5; tick();
        chk("t1.byte5", 32'(rd_data), 32'(fb[5]));
        release_one();
        check_state("t1.rel", 0);
        release_one();   // empty queue: must be ignored
        check_state("t1.relempty", 0);

        // fill both slots, third dropped, release then fourth stored
        build(64, 1'b1); send(64, 7, 1'b0);
        build(70, 1'b1); send(70, 3, 1'b0);
        build(66, 1'b1); send(66, 7, 1'b0);
        check_state("t2.full", 4);
        release_one();
        check_state("t2.rel", 4);
        build(72, 1'b1); send(72, 7, 1'b0);
        check_state("t2.fourth", 4);
        release_one();
        check_state("t2.rel2", 4);
        release_one();

        // commit and release in the same cycle
        build(40, 1'b1); send(40, 7, 1'b0);
        build(50, 1'b1); send(50, 7, 1'b1);
        check_state("simul", 4);
        release_one();

        // overlong then exact-size frame
        build(MAXB + 1, 1'b1); send(MAXB + 1, 7, 1'b0);
        check_state("t3.over", 0);
        build(MAXB, 1'b1); send(MAXB, 7, 1'b0);
        check_state("t3.exact", 2);
        rd_addr = 10'(MAXB - 1); tick();
        chk("t3.last", 32'(rd_data), 32'(fb[MAXB-1]));
        release_one();

        // preamble abort, garbage start, bad byte in preamble, runts, minimum length
        rx_dv = 1'b1; rx_data = 8'h55; tick(); tick(); tick();
        rx_dv = 1'b0; tick();
        check_state("t4.abort", 0);
        rx_dv = 1'b1; rx_data = 8'hA0; tick(); rx_data = 8'h55; tick(); tick();
        rx_dv = 1'b0; tick();
        exp_drop++;
        check_state("t4.garbage", 0);
        rx_dv = 1'b1; rx_data = 8'h55; tick(); rx_data = 8'h12; tick(); rx_data = 8'hD5; tick();
        rx_dv = 1'b0; tick();
        exp_drop++;
        check_state("t4.badpre", 0);
        build(10, 1'b1); send(10, 7, 1'b0);
        check_state("t4.runt10", 0);
        build(MIN_LEN - 1, 1'b1); send(MIN_LEN - 1, 7, 1'b0);
        check_state("t4.runt13", 0);
        build(MIN_LEN, 1'b1); send(MIN_LEN, 7, 1'b0);
        check_state("t4.min", 3);
        release_one();

        // corrupted FCS
        build(60, 1'b1);
        fb[20] = fb[20] ^ 8'h01;
        send(60, 7, 1'b0);
        check_state("t5.corrupt", 3);
        release_one();

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 7) == 0) len = $urandom_range(4, MIN_LEN - 1);
            else len = $urandom_range(MIN_LEN, 120);
            build(len, $urandom_range(0, 3) != 0);
            send(len, $urandom_range(1, 7), (exp_lens.size() == 1) && ($urandom_range(0, 3) == 0));
            check_state("rnd", 2);
            if ($urandom_range(0, 2) == 0) release_one();
        end
        while (exp_lens.size() != 0) release_one();

        // reset in the middle of a frame with one frame stored
        build(30, 1'b1); send(30, 7, 1'b0);
        build(40, 1'b1);
        rx_dv = 1'b1; rx_data = 8'h55; tick(); rx_data = 8'hD5; tick();
        for (int i = 0; i < 10; i++) begin rx_data = fb[i]; tick(); end
        reset_n = 1'b0; rx_data = fb[10];
        tick();
        exp_lens.delete(); exp_bytes.delete(); exp_drop = 0; exp_fcs = 0;
        check_state("t6.reset", 0);
        chk("t6.rd", 32'(rd_data), 0);
        reset_n = 1'b1; rx_dv = 1'b0; tick();
        check_state("t6.after", 0);
        build(48, 1'b1); send(48, 7, 1'b0);
        check_state("t6.good", 4);
        a = 0;
        rd_addr = a[ADDR_W-1:0]; tick();
        chk("t6.byte0", 32'(rd_data), 32'(fb[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
